vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 32-bit data/text RAM between the pipelined CPU data port and the VGA text fetcher.
//  VGA is a streaming read port with priority. CPU accesses use a held request/ready handshake.
//  A bounded-wait counter guarantees CPU progress. The RAM sees registered address/we/wdata,
//  so the memory mux leaves the top-level combinational path.
// PARAMETERS
//  ADDR_W        15  word-address width (32k x 32 RAM)
//  CPU_MAX_WAIT   8  max consecutive lost arbitration cycles before CPU is forced to win (legal 1..255)
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  cpu_req    in   1       CPU access request; held with addr/we/wdata stable until cpu_ready
//  cpu_we     in   4       byte write enables; 0 = read
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   32      CPU write data
//  cpu_rdata  out  32      read data; valid while cpu_ready=1, holds last value otherwise
//  cpu_ready  out  1       one-cycle completion pulse (reads and writes)
//  vga_req    in   1       VGA fetch request for vga_addr
//  vga_addr   in   ADDR_W  VGA word address
//  vga_gnt    out  1       combinational; request accepted this cycle
//  vga_rdata  out  32      fetched word; valid while vga_valid=1
//  vga_valid  out  1       returns in order, 2 cycles after the accepting cycle
//  mem_addr   out  ADDR_W  registered RAM address
//  mem_we     out  4       registered RAM byte enables
//  mem_wdata  out  32      registered RAM write data
//  mem_rdata  in   32      RAM read data; valid the cycle after mem_addr is presented
// BEHAVIOUR
//  - Reset (async): mem_addr=0, mem_we=0, mem_wdata=0, cpu_ready=0, vga_valid=0, cpu_rdata=0, vga_rdata=0.
//    Wait counter, outstanding flag and owner pipeline are also cleared.
//  - Arbitration is combinational in cycle t.
//    cpu_eligible = cpu_req & ~cpu_outstanding.
//    CPU wins if cpu_eligible & (~vga_req | wait_cnt==CPU_MAX_WAIT). Otherwise VGA wins if vga_req.
//    If neither wins, the slot is idle: mem_we=0 and mem_addr holds its previous value.
//  - Issue: at posedge ending cycle t, the winner's addr/we/wdata go to mem_*. owner1 is set to NONE, CPU or VGA.
//  - At the next edge, owner1 moves to owner2. In cycle t+2:
//    owner2=CPU  -> cpu_ready=1, cpu_rdata=mem_rdata.
//    owner2=VGA  -> vga_valid=1, vga_rdata=mem_rdata.
//  - Write latency equals read latency: cpu_ready in t+2, and the RAM commits at the t+1 edge.
//  - cpu_outstanding is set on CPU grant and cleared in the cpu_ready cycle.
//    It blocks re-grant of the still-held cpu_req, so the CPU has at most one access in flight.
//  - VGA may be granted every cycle, with up to 2 accesses in flight. Responses stay in strict issue order.
//  - wait_cnt increments by 1 each cycle cpu_eligible loses to VGA, saturating at CPU_MAX_WAIT.
//    It clears to 0 on CPU grant.
//  - mem_we is nonzero only in the cycle after a CPU write grant; it is never nonzero for VGA.
//  - Simultaneous cpu_ready and vga_valid cannot occur, because only one owner exists per slot.
//  - Changing cpu_req/cpu_addr before cpu_ready is illegal; the bench asserts against it.
//  - Reset mid-operation drops all in-flight accesses: no ready/valid pulses afterwards, and mem_we=0 immediately.
// STRUCTURE
//  - Package vram_arb_pkg: owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_VGA=2'd2.
//    Also holds the default width constant VRAM_ADDR_W=15.
//  - Flat module, no sub-module: grant logic, issue registers, 2-deep owner shift pipeline, wait counter.
// TESTING
//  1. CPU read alone, RAM[0x0010]=0xDEADBEEF, cpu_req at cyc0 -> mem_addr=0x0010 in cyc1;
//     cpu_ready=1 with cpu_rdata=0xDEADBEEF in cyc2 only.
//  2. cpu_req and vga_req both at cyc0, vga_req dropped after its grant -> vga_gnt cyc0, CPU issued cyc1;
//     vga_valid cyc2, cpu_ready cyc3.
//  3. CPU_MAX_WAIT=3, vga_req held high continuously, cpu_req at cyc0 -> vga_gnt=1 cyc0-2, vga_gnt=0 in cyc3 (CPU wins);
//     cpu_ready cyc5, vga_gnt=1 again from cyc4.
//  4. CPU write we=4'b0011 wdata=0x12345678 addr=0x0020 over 0xAABBCCDD -> mem_we=0011 in cyc1, cpu_ready cyc2;
//     a later read returns 0xAABB5678.
//  5. VGA burst addr 0x1800..0x1803 on consecutive cycles -> vga_valid cycles 2-5 with data in address order;
//     a held cpu_req is serviced within CPU_MAX_WAIT+1 cycles.
//  6. CPU granted cyc0, rst pulsed in cyc1 -> mem_we=0 and no cpu_ready;
//     after release, a fresh cpu_req completes normally with wait_cnt starting at 0.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arb_pkg: shared constants and owner encoding for the VRAM arbiter.
// No ports; imported by the interface, the arbiter and the bench.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU data port and VGA fetch port of the VRAM arbiter.
// master = clients (CPU + VGA fetcher), slave = arbiter.
interface vram_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
) ();

  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [31:0]       vga_rdata;
  logic              vga_valid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rdata, vga_valid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rdata, vga_valid
  );

endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 32-bit RAM port between CPU data and VGA text fetch.
// Ports: clk, rst (async high), bus (slave), mem_addr/we/wdata out, mem_rdata in.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  vram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] MAXW = 8'(CPU_MAX_WAIT);

  owner_e            own1_q, own1_d;
  owner_e            own2_q;
  logic [7:0]        wait_q, wait_d;
  logic              outst_q, outst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       crd_q, crd_d;
  logic [31:0]       vrd_q, vrd_d;

  logic cpu_elig;
  logic cpu_win;
  logic vga_win;

  // VGA has priority unless the CPU has starved
  // for CPU_MAX_WAIT consecutive lost cycles.
  always_comb begin
    cpu_elig = bus.cpu_req & ~outst_q;
    cpu_win  = cpu_elig
             & (~bus.vga_req | (wait_q == MAXW));
    vga_win  = bus.vga_req & ~cpu_win;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      own1_q  <= OWN_NONE;
      own2_q  <= OWN_NONE;
      wait_q  <= '0;
      outst_q <= 1'b0;
      crd_q   <= '0;
      vrd_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      own1_q  <= own1_d;
      own2_q  <= own1_q;
      wait_q  <= wait_d;
      outst_q <= outst_d;
      crd_q   <= crd_d;
      vrd_q   <= vrd_d;
    end
  end

  // next state
  always_comb begin
    addr_d  = addr_q;
    we_d    = '0;
    wdata_d = wdata_q;
    own1_d  = OWN_NONE;
    unique case (1'b1)
      cpu_win: begin
        addr_d  = bus.cpu_addr;
        we_d    = bus.cpu_we;
        wdata_d = bus.cpu_wdata;
        own1_d  = OWN_CPU;
      end
      vga_win: begin
        addr_d = bus.vga_addr;
        own1_d = OWN_VGA;
      end
      default: ;
    endcase

    wait_d = wait_q;
    if (cpu_win) begin
      wait_d = '0;
    end else if (cpu_elig && vga_win
                 && wait_q != MAXW) begin
      wait_d = wait_q + 8'd1;
    end

    // Held cpu_req must not re-win until
    // its single access has completed.
    outst_d = outst_q;
    if (cpu_win) begin
      outst_d = 1'b1;
    end else if (own2_q == OWN_CPU) begin
      outst_d = 1'b0;
    end

    crd_d = crd_q;
    vrd_d = vrd_q;
    if (own2_q == OWN_CPU) crd_d = mem_rdata;
    if (own2_q == OWN_VGA) vrd_d = mem_rdata;
  end

  // outputs
  always_comb begin
    bus.vga_gnt   = vga_win;
    bus.cpu_ready = (own2_q == OWN_CPU);
    bus.vga_valid = (own2_q == OWN_VGA);
    bus.cpu_rdata = bus.cpu_ready ? mem_rdata : crd_q;
    bus.vga_rdata = bus.vga_valid ? mem_rdata : vrd_q;
    mem_addr      = addr_q;
    mem_we        = we_q;
    mem_wdata     = wdata_q;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a synchronous RAM model.
// Ports: none; CPU_MAX_WAIT=3 so the starvation bound is short.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW   = VRAM_ADDR_W;
  localparam int MAXW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   ram [0:(1<<AW)-1];

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  logic          pend;
  logic [AW-1:0] p_addr;
  logic [3:0]    p_we;

  vram_arbiter_if #(.ADDR_W(AW)) bus ();

  vram_arbiter #(
    .ADDR_W(AW),
    .CPU_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we[0]) ram[mem_addr][7:0]   <= mem_wdata[7:0];
    if (mem_we[1]) ram[mem_addr][15:8]  <= mem_wdata[15:8];
    if (mem_we[2]) ram[mem_addr][23:16] <= mem_wdata[23:16];
    if (mem_we[3]) ram[mem_addr][31:24] <= mem_wdata[31:24];
    mem_rdata <= ram[mem_addr];
  end

  // CPU request must stay stable until cpu_ready
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (pend && !bus.cpu_ready) begin
      assert (bus.cpu_req === 1'b1
              && bus.cpu_addr === p_addr
              && bus.cpu_we === p_we)
      else begin
        nchk++;
        nfail++;
        $error("FAIL proto: cpu_req/addr changed before ready");
      end
    end else if (pend && bus.cpu_ready) begin
      pend <= 1'b0;
    end else if (bus.cpu_req) begin
      pend   <= 1'b1;
      p_addr <= bus.cpu_addr;
      p_we   <= bus.cpu_we;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic r, input logic [3:0] we,
                     input logic [AW-1:0] a,
                     input logic [31:0] d);
    bus.cpu_req   = r;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic vga(input logic r, input logic [AW-1:0] a);
    bus.vga_req  = r;
    bus.vga_addr = a;
  endtask

  function automatic logic [31:0] vdat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    rst = 1'b1;
    cpu(1'b0, 4'h0, '0, '0);
    vga(1'b0, '0);
    ram['h0010] <= 32'hDEAD_BEEF;
    ram['h0020] <= 32'hAABB_CCDD;
    ram['h0030] <= 32'h3030_3030;
    for (int i = 0; i < 4; i++) ram['h1800 + i] <= vdat(i);

    // reset state
    mid();
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_we",    32'(mem_we), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_crdy",  32'(bus.cpu_ready), 32'h0);
    chk("rst_vval",  32'(bus.vga_valid), 32'h0);
    chk("rst_crd",   bus.cpu_rdata, 32'h0);
    chk("rst_vrd",   bus.vga_rdata, 32'h0);
    nxt();
    rst = 1'b0;
    nxt();

    // 1: CPU read alone
    cpu(1'b1, 4'h0, 'h0010, '0);
    mid();
    chk("t1_gnt0", 32'(bus.vga_gnt), 32'h0);
    chk("t1_rdy0", 32'(bus.cpu_ready), 32'h0);
    nxt(); mid();
    chk("t1_addr", 32'(mem_addr), 32'h10);
    chk("t1_rdy1", 32'(bus.cpu_ready), 32'h0);
    nxt(); mid();
    chk("t1_rdy2", 32'(bus.cpu_ready), 32'h1);
    chk("t1_data", bus.cpu_rdata, 32'hDEAD_BEEF);
    nxt();
    cpu(1'b0, 4'h0, '0, '0);
    mid();
    chk("t1_rdy3", 32'(bus.cpu_ready), 32'h0);
    chk("t1_hold", bus.cpu_rdata, 32'hDEAD_BEEF);
    nxt();

    // 2: simultaneous CPU and VGA
    cpu(1'b1, 4'h0, 'h0010, '0);
    vga(1'b1, 'h1800);
    mid();
    chk("t2_gnt0", 32'(bus.vga_gnt), 32'h1);
    nxt();
    vga(1'b0, '0);
    mid();
    chk("t2_gnt1", 32'(bus.vga_gnt), 32'h0);
    chk("t2_addr1", 32'(mem_addr), 32'h1800);
    nxt(); mid();
    chk("t2_vval2", 32'(bus.vga_valid), 32'h1);
    chk("t2_vdat2", bus.vga_rdata, vdat(0));
    chk("t2_addr2", 32'(mem_addr), 32'h10);
    chk("t2_crdy2", 32'(bus.cpu_ready), 32'h0);
    nxt(); mid();
    chk("t2_crdy3", 32'(bus.cpu_ready), 32'h1);
    chk("t2_vval3", 32'(bus.vga_valid), 32'h0);
    chk("t2_cdat3", bus.cpu_rdata, 32'hDEAD_BEEF);
    nxt();
    cpu(1'b0, 4'h0, '0, '0);
    nxt();

    // 3: starvation bound with VGA held high
    cpu(1'b1, 4'h0, 'h0020, '0);
    vga(1'b1, 'h1801);
    for (int c = 0; c < 6; c++) begin
      mid();
      chk($sformatf("t3_gnt%0d", c), 32'(bus.vga_gnt),
          (c == 3) ? 32'h0 : 32'h1);
      chk($sformatf("t3_rdy%0d", c), 32'(bus.cpu_ready),
          (c == 5) ? 32'h1 : 32'h0);
      if (c == 5) begin
        chk("t3_cdat", bus.cpu_rdata, 32'hAABB_CCDD);
        chk("t3_vval5", 32'(bus.vga_valid), 32'h0);
      end
      nxt();
    end
    cpu(1'b0, 4'h0, '0, '0);
    vga(1'b0, '0);
    mid();
    chk("t3_vval6", 32'(bus.vga_valid), 32'h1);
    chk("t3_vdat6", bus.vga_rdata, vdat(1));
    nxt(); mid();
    chk("t3_vval7", 32'(bus.vga_valid), 32'h1);
    nxt(); nxt();

    // 4: partial write then read-back
    cpu(1'b1, 4'b0011, 'h0020, 32'h1234_5678);
    nxt(); mid();
    chk("t4_we1", 32'(mem_we), 32'h3);
    chk("t4_addr1", 32'(mem_addr), 32'h20);
    chk("t4_wd1", mem_wdata, 32'h1234_5678);
    nxt(); mid();
    chk("t4_rdy2", 32'(bus.cpu_ready), 32'h1);
    chk("t4_we2", 32'(mem_we), 32'h0);
    nxt();
    cpu(1'b1, 4'h0, 'h0020, '0);
    nxt(); nxt(); mid();
    chk("t4_rdrdy", 32'(bus.cpu_ready), 32'h1);
    chk("t4_merge", bus.cpu_rdata, 32'hAABB_5678);
    nxt();
    cpu(1'b0, 4'h0, '0, '0);
    nxt();

    // 5: VGA burst, in-order streaming
    for (int i = 0; i < 6; i++) begin
      if (i < 4) vga(1'b1, AW'('h1800 + i));
      else       vga(1'b0, '0);
      mid();
      if (i < 4)
        chk($sformatf("t5_gnt%0d", i),
            32'(bus.vga_gnt), 32'h1);
      if (i >= 2) begin
        chk($sformatf("t5_vval%0d", i),
            32'(bus.vga_valid), 32'h1);
        chk($sformatf("t5_vdat%0d", i),
            bus.vga_rdata, vdat(i - 2));
      end
      nxt();
    end
    mid();
    chk("t5_vval6", 32'(bus.vga_valid), 32'h0);
    nxt();

    // 6: reset right after a CPU write grant
    cpu(1'b1, 4'hF, 'h0030, 32'h5555_5555);
    mid();
    chk("t6_gnt0", 32'(bus.vga_gnt), 32'h0);
    nxt();
    rst = 1'b1;
    cpu(1'b0, 4'h0, '0, '0);
    #1;
    chk("t6_we_rst", 32'(mem_we), 32'h0);
    chk("t6_addr_rst", 32'(mem_addr), 32'h0);
    mid();
    chk("t6_rdy1", 32'(bus.cpu_ready), 32'h0);
    nxt(); mid();
    chk("t6_rdy2", 32'(bus.cpu_ready), 32'h0);
    nxt();
    rst = 1'b0;
    mid();
    chk("t6_rdy3", 32'(bus.cpu_ready), 32'h0);
    chk("t6_ram", ram['h0030], 32'h3030_3030);
    nxt();

    // build up wait count, then reset before CPU wins
    cpu(1'b1, 4'h0, 'h0010, '0);
    vga(1'b1, 'h1800);
    nxt(); nxt();
    rst = 1'b1;
    cpu(1'b0, 4'h0, '0, '0);
    vga(1'b0, '0);
    nxt();
    rst = 1'b0;
    mid();
    chk("t6_vval_rst", 32'(bus.vga_valid), 32'h0);
    nxt(); mid();
    chk("t6_vval_rst2", 32'(bus.vga_valid), 32'h0);
    nxt();

    // fresh request: wait count restarts at zero
    cpu(1'b1, 4'h0, 'h0010, '0);
    vga(1'b1, 'h1802);
    for (int c = 0; c < 6; c++) begin
      mid();
      chk($sformatf("t6_gnt%0d", c), 32'(bus.vga_gnt),
          (c == MAXW) ? 32'h0 : 32'h1);
      if (c == 5) begin
        chk("t6_frdy", 32'(bus.cpu_ready), 32'h1);
        chk("t6_fdat", bus.cpu_rdata, 32'hDEAD_BEEF);
      end
      nxt();
    end
    cpu(1'b0, 4'h0, '0, '0);
    vga(1'b0, '0);
    nxt(); nxt(); nxt();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
